// File: rtl/rain_sequencer.sv
// rain_sequencer: frame-rate animation controller for the glyph-rain VGA path.
//   Runs on the pixel clock. It turns each vsync rising edge into a one-cycle
//   frame tick and advances the animation counter at a selectable rate. It
//   also supports pause and single-step, a sticky wrap flag and a palette id.
//
// Ports:
//   clk        pixel clock (only clock)
//   reset      synchronous, active-high
//   vsync      frame sync; a frame starts on its 0->1 transition
//   pause      level; 1 freezes the counter
//   step       level; a rising edge requests one advance while paused
//   speed      frames per advance = 1,2,4,8 for speed 0..3
//   pal_auto   1 = auto palette cycling (only with the macro below)
//   pal_sel    manual palette id
//   counter    animation counter (CNT_W bits)
//   rst_drop   sticky, set once the counter wraps
//   pid        palette id to the palette ROM
//   frame_tick one-cycle pulse per vsync rising edge
//
// Build option: define RAIN_SEQ_PALETTE_CYCLE_EN to compile in auto palette
// cycling. Without it, pid is simply pal_sel registered, and pal_auto and
// PAL_LOG2 are ignored.
module rain_sequencer #(
  parameter int CNT_W    = 10,
  parameter int PAL_LOG2 = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             pause,
  input  logic             step,
  input  logic [1:0]       speed,
  input  logic             pal_auto,
  input  logic [1:0]       pal_sel,
  output logic [CNT_W-1:0] counter,
  output logic             rst_drop,
  output logic [1:0]       pid,
  output logic             frame_tick
);

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_STEP} state_t;

  state_t     state;
  logic [2:0] div_cnt, div_nxt, div_lim;
  logic       vs_q, st_q;
  logic       tick, step_edge, adv;

  assign tick      = vsync & ~vs_q;
  assign step_edge = step & ~st_q;

  always_comb begin
    case (speed)
      2'd0:    div_lim = 3'd0;
      2'd1:    div_lim = 3'd1;
      2'd2:    div_lim = 3'd3;
      default: div_lim = 3'd7;
    endcase
  end

  // Advance decision. A pause in RUN wins over a same-cycle tick. A step
  // advance leaves the divider untouched. The >= compare keeps a mid-count
  // speed reduction from stalling the divider.
  always_comb begin
    adv     = 1'b0;
    div_nxt = div_cnt;
    case (state)
      S_RUN: begin
        if (!pause && tick) begin
          if (div_cnt >= div_lim) begin
            div_nxt = 3'd0;
            adv     = 1'b1;
          end else begin
            div_nxt = div_cnt + 3'd1;
          end
        end
      end
      S_STEP:  adv = pause & tick;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RUN;
      div_cnt    <= 3'd0;
      vs_q       <= 1'b0;
      st_q       <= 1'b0;
      counter    <= '0;
      rst_drop   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync;
      st_q       <= step;
      frame_tick <= tick;
      div_cnt    <= div_nxt;
      if (adv) begin
        counter <= counter + 1'b1;
        if (&counter) rst_drop <= 1'b1;
      end
      case (state)
        S_RUN:    if (pause) state <= S_PAUSED;
        S_PAUSED: begin
          if (!pause)         state <= S_RUN;
          else if (step_edge) state <= S_STEP;
        end
        S_STEP: begin
          // Dropping pause discards a pending step.
          if (!pause)    state <= S_RUN;
          else if (tick) state <= S_PAUSED;
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef RAIN_SEQ_PALETTE_CYCLE_EN
  // Auto mode bumps pid whenever the low PAL_LOG2 bits roll over. Manual mode
  // tracks pal_sel, so switching to auto continues from the current pid.
  always_ff @(posedge clk) begin
    if (reset)
      pid <= 2'd0;
    else if (!pal_auto)
      pid <= pal_sel;
    else if (adv && (&counter[PAL_LOG2-1:0]))
      pid <= pid + 2'd1;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) pid <= 2'd0;
    else       pid <= pal_sel;
  end

  logic unused_pal;
  assign unused_pal = pal_auto ^ (PAL_LOG2 != 0);
`endif

endmodule

// File: tb/tb_rain_sequencer.sv
module tb_rain_sequencer;
  logic       clk = 1'b0;
  logic       reset, vsync, pause, step, pal_auto;
  logic [1:0] speed, pal_sel;
  logic [9:0] counter;
  logic       rst_drop, frame_tick;
  logic [1:0] pid;

  rain_sequencer #(.CNT_W(10), .PAL_LOG2(2)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause), .step(step),
    .speed(speed), .pal_auto(pal_auto), .pal_sel(pal_sel),
    .counter(counter), .rst_drop(rst_drop), .pid(pid), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0, ft_cnt = 0;

  always @(negedge clk) if (frame_tick === 1'b1) ft_cnt++;

  typedef struct {
    string      name;
    logic       pause;
    logic       step;
    logic [1:0] speed;
    logic [1:0] pal_sel;
    int         pulses;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    vsync = 1'b1; cyc();
    vsync = 1'b0; cyc();
  endtask

  task automatic step_edge();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
  endtask

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; pause = 1'b0; step = 1'b0;
    speed = 2'd0; pal_auto = 1'b0; pal_sel = 2'd0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    // name, pause, step, speed, pal_sel, pulses, expected counter
    tbl[0]  = '{"spd2_12",     1'b0, 1'b0, 2'd2, 2'd1, 12, 3};
    tbl[1]  = '{"spd2_div2",   1'b0, 1'b0, 2'd2, 2'd2, 2,  3};
    tbl[2]  = '{"spd0_resume", 1'b0, 1'b0, 2'd0, 2'd3, 1,  4};
    tbl[3]  = '{"spd1_3",      1'b0, 1'b0, 2'd1, 2'd0, 3,  5};
    tbl[4]  = '{"paused_5",    1'b1, 1'b0, 2'd0, 2'd1, 5,  5};
    tbl[5]  = '{"step_1",      1'b1, 1'b1, 2'd0, 2'd2, 1,  6};
    tbl[6]  = '{"step_nopls",  1'b1, 1'b1, 2'd0, 2'd3, 0,  6};
    tbl[7]  = '{"step_pend",   1'b1, 1'b0, 2'd0, 2'd0, 1,  7};
    tbl[8]  = '{"paused_2",    1'b1, 1'b0, 2'd0, 2'd1, 2,  7};
    tbl[9]  = '{"run_divkeep", 1'b0, 1'b0, 2'd1, 2'd2, 1,  8};
    tbl[10] = '{"run_stepign", 1'b0, 1'b1, 2'd0, 2'd3, 1,  9};

    do_reset();
    chk("rst.counter", counter, 0);
    chk("rst.rst_drop", rst_drop, 0);
    chk("rst.pid", pid, 0);
    chk("rst.frame_tick", frame_tick, 0);

    // Full wrap at speed 0.
    t0 = ft_cnt;
    repeat (1023) pulse();
    chk("wrap.cnt1023", counter, 1023);
    chk("wrap.drop_pre", rst_drop, 0);
    pulse();
    chk("wrap.cnt0", counter, 0);
    chk("wrap.drop_set", rst_drop, 1);
    pulse();
    chk("wrap.drop_sticky", rst_drop, 1);
    chk("wrap.ticks", ft_cnt - t0, 1025);

    do_reset();
    chk("rst2.rst_drop", rst_drop, 0);
    chk("rst2.counter", counter, 0);

    for (int i = 0; i < 11; i++) begin
      pause = tbl[i].pause; speed = tbl[i].speed; pal_sel = tbl[i].pal_sel;
      cyc();
      if (tbl[i].step) step_edge();
      t0 = ft_cnt;
      repeat (tbl[i].pulses) pulse();
      chk({tbl[i].name, ".cnt"}, counter, tbl[i].exp_cnt);
      chk({tbl[i].name, ".ticks"}, ft_cnt - t0, tbl[i].pulses);
      chk({tbl[i].name, ".pid"}, pid, tbl[i].pal_sel);
    end

    // Pause and tick in the same cycle: pause wins.
    t0 = ft_cnt;
    pause = 1'b1; vsync = 1'b1; cyc();
    vsync = 1'b0; cyc();
    chk("pause_tick.cnt", counter, 9);
    chk("pause_tick.ticks", ft_cnt - t0, 1);

    // Pending step discarded when pause drops; divider decides afterwards.
    step_edge();
    pause = 1'b0; speed = 2'd1; cyc();
    pulse();
    chk("step_drop.cnt", counter, 9);
    pulse();
    chk("step_drop.adv", counter, 10);

    // Reset with a step pending.
    pause = 1'b1; speed = 2'd0; cyc();
    step_edge();
    reset = 1'b1; cyc();
    reset = 1'b0; pause = 1'b0;
    chk("midrst.cnt", counter, 0);
    chk("midrst.ft", frame_tick, 0);
    pulse();
    chk("midrst.run", counter, 1);

    // vsync held high through reset release.
    reset = 1'b1; vsync = 1'b1; cyc(3);
    reset = 1'b0;
    t0 = ft_cnt;
    cyc(6);
    chk("vshigh.ticks", ft_cnt - t0, 1);
    chk("vshigh.cnt", counter, 1);
    vsync = 1'b0; cyc();
    vsync = 1'b1; cyc();
    vsync = 1'b0; cyc();
    chk("vshigh.ticks2", ft_cnt - t0, 2);
    chk("vshigh.cnt2", counter, 2);

    // Palette.
    do_reset();
`ifdef RAIN_SEQ_PALETTE_CYCLE_EN
    pal_auto = 1'b1; cyc();
    repeat (4) pulse();
    chk("pal.auto4", pid, 1);
    repeat (4) pulse();
    chk("pal.auto8", pid, 2);
    pal_auto = 1'b0; pal_sel = 2'd3; cyc();
    chk("pal.manual", pid, 3);
`else
    pal_auto = 1'b1; pal_sel = 2'd2; cyc();
    repeat (8) pulse();
    chk("pal.fixed", pid, 2);
    pal_sel = 2'd3; cyc();
    chk("pal.manual", pid, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/rain_sequencer.md
# rain_sequencer

Frame-rate animation controller for the glyph-rain VGA datapath. It runs on the pixel clock and replaces the vsync-clocked frame counter. It derives a one-cycle frame tick from `vsync` and advances the 10-bit animation counter at a selectable rate, with pause and single-step support. It also owns the sticky intro-complete flag (`rst_drop`) and the 2-bit palette id feeding the palette ROM, which can be manual or auto-cycled.

## Interface

Parameters:
- `CNT_W`, 10: animation counter width.
- `PAL_LOG2`, 8: auto palette advances every 2^PAL_LOG2 counter advances; valid range 1..CNT_W.

Ports:
- `clk`: input, 1 bit. Pixel clock, the only clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `vsync`: input, 1 bit. From `hvsync_generator`. A frame starts on the 0→1 transition.
- `pause`: input, 1 bit. Level. 1 freezes the counter.
- `step`: input, 1 bit. Level. A rising edge requests one advance while paused.
- `speed`: input, 2 bits. Frames per advance are 1, 2, 4 or 8 for speed 0..3.
- `pal_auto`: input, 1 bit. 1 selects auto palette cycling.
- `pal_sel`: input, 2 bits. Manual palette id.
- `counter`: output, CNT_W bits. Animation counter.
- `rst_drop`: output, 1 bit. Sticky; 1 once the counter has wrapped.
- `pid`: output, 2 bits. Palette id.
- `frame_tick`: output, 1 bit. One-cycle pulse per vsync rising edge.

## Operation

- Reset values:
  - outputs: `counter`=0, `rst_drop`=0, `pid`=0, `frame_tick`=0;
  - internal: state RUN, `div_cnt`=0, `vs_q`=0, `st_q`=0.
- Edge detect:
  - `vs_q` and `st_q` register `vsync` and `step` every cycle.
  - A tick is `vsync & ~vs_q`. A step edge is `step & ~st_q`.
- Divider (RUN only): on each tick,
  - if `div_cnt >= (1<<speed)-1`, then `div_cnt`←0 and the counter advances;
  - otherwise `div_cnt`++.
  - The `>=` compare keeps a speed reduction mid-count from stalling.
  - `div_cnt` is 3 bits.
- Advance: `counter`←`counter+1`, wrapping modulo 2^CNT_W.
  - If the counter is all-ones before the advance, `rst_drop`←1 on the same edge.
  - `rst_drop` is cleared only by `reset`.
- FSM states:
  - RUN:
    - `pause`=1 → PAUSED; this takes priority over a tick in the same cycle, so there is no advance.
    - A step edge in RUN is ignored.
  - PAUSED:
    - counter and `div_cnt` are held.
    - `pause`=0 → RUN; `div_cnt` is resumed, not cleared.
    - Step edge with `pause`=1 → STEP.
  - STEP:
    - `pause`=0 → RUN; the pending step is discarded.
    - Otherwise, on the next tick: exactly one advance, `div_cnt` untouched, then → PAUSED.
    - Step edges while in STEP are ignored.
- Palette, auto mode (`pal_auto`=1): on any advance where `counter[PAL_LOG2-1:0]` is all-ones before the advance, `pid`←`pid+1` mod 4.
- Palette, manual mode (`pal_auto`=0): `pid`←`pal_sel` every cycle.
  - Switching to auto continues from the current `pid`.
- `frame_tick` pulses on every tick regardless of state.

## Timing

- Latency:
  - Tick detected at edge E (`vsync`=1, `vs_q`=0).
  - `frame_tick`, `counter`, `rst_drop` and `pid` all update at E, visible the cycle after.
  - `frame_tick` is high for exactly one cycle.
- `vsync` held high for many cycles produces exactly one tick.
- `pause` and state transitions take effect at the next edge. Pause and tick in the same cycle: the pause wins.
- Reset asserted mid-operation (any state, mid-divide, STEP pending): all outputs and state return to reset values at the next edge.
- A `vsync` rise during reset is not latched; `vs_q` is 0 after reset, so a `vsync` already high when reset is released produces one tick on the first cycle after release.
- Inputs are synchronous to `clk`; no synchronizers are provided.

## Configuration

- `RAIN_SEQ_PALETTE_CYCLE_EN` defined:
  - auto palette cycling is compiled in as described above.
- Not defined:
  - `pid` is `pal_sel` registered every cycle;
  - `pal_auto` and `PAL_LOG2` are ignored;
  - no palette counter logic is present.

## Test plan

- Reset, then 1024 vsync pulses with `speed`=0 → counter 1023 with `rst_drop`=0 after 1023 pulses; after pulse 1024 the counter is 0 and `rst_drop`=1, and it stays 1.
- `speed`=2, 12 vsync pulses → counter=3 and 12 `frame_tick` pulses. Then switch to `speed`=0 with `div_cnt`=2 → advance on the very next tick.
- `pause`=1, 5 pulses → counter unchanged. Step edge, then one pulse → counter+1, state PAUSED. A second step edge with no pulse → no change.
- `pause` rises in the same cycle as a tick → no advance. STEP pending and then `pause` drops → next tick advances via the divider, without an extra step.
- With the macro: `pal_auto`=1, `PAL_LOG2`=2, 8 advances → `pid` goes 0→1→2. Then `pal_auto`=0 with `pal_sel`=3 → `pid`=3 the next cycle.
- `vsync` held high through reset release → exactly one `frame_tick` and no further ticks until `vsync` falls and rises again.
